num_ascii_formatter: RTL

//  Hardware counterpart of $display number formatting: accepts one WIDTH-bit value plus a format code.

---
 rtl/num_fmt_pkg.sv | 54 +++++
 rtl/num_fmt_dec_digit.sv | 48 ++++
 rtl/num_ascii_formatter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/num_fmt_pkg.sv
// Shared constants and helpers for the number-to-ASCII formatter.
package num_fmt_pkg;

   // Format codes on in_fmt
   localparam logic [1:0] FMT_BIN  = 2'b00;
   localparam logic [1:0] FMT_HEX  = 2'b01;
   localparam logic [1:0] FMT_UDEC = 2'b10;
   localparam logic [1:0] FMT_SDEC = 2'b11;

   // FSM state encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SIGN = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_EMIT = 2'd3;

   // ASCII constants
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   // Number of decimal digits needed for 2^width-1 (elaboration-time only)
   function automatic int unsigned dec_digits(input int unsigned width);
      longint unsigned v;
      int unsigned     n;
      v = (64'd1 << width) - 64'd1;
      n = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (v != 64'd0) begin
            n++;
            v = v / 64'd10;
         end
      end
      if (n == 0) n = 1;
      return n;
   endfunction

   // 10^k for k = 0..9
   function automatic logic [31:0] pow10(input int unsigned k);
      case (k)
         0:       return 32'd1;
         1:       return 32'd10;
         2:       return 32'd100;
         3:       return 32'd1000;
         4:       return 32'd10000;
         5:       return 32'd100000;
         6:       return 32'd1000000;
         7:       return 32'd10000000;
         8:       return 32'd100000000;
         9:       return 32'd1000000000;
         default: return 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/num_fmt_dec_digit.sv
// Repeated-subtraction decimal digit extractor: counts how many times pow
// fits into the remainder, one subtraction per cycle.
module num_fmt_dec_digit
   import num_fmt_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] rem_in,
   input  logic [31:0]      pow,
   output logic [3:0]       digit,
   output logic [WIDTH-1:0] rem_out,
   output logic             done
);

   logic [WIDTH-1:0] rem_q;
   logic [3:0]       cnt_q;
   logic             busy_q;
   logic             ge;

   assign ge      = 32'(rem_q) >= pow;
   assign done    = busy_q && !ge;
   assign digit   = cnt_q;
   assign rem_out = rem_q;

   // Load on start, then subtract pow each cycle until the remainder drops below it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= rem_in;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (ge) begin
            rem_q <= rem_q - WIDTH'(pow);
            cnt_q <= cnt_q + 4'd1;
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/num_ascii_formatter.sv
// Streams the ASCII text of a WIDTH-bit value (bin / hex / udec / sdec) one
// character per valid/ready beat.
// Optional build macro: FMT_ZERO_SUPPRESS_EN skips leading zero digits.
module num_ascii_formatter
   import num_fmt_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_fmt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last
);

`ifdef FMT_ZERO_SUPPRESS_EN
   localparam bit ZERO_SUPPRESS = 1'b1;
`else
   localparam bit ZERO_SUPPRESS = 1'b0;
`endif

   localparam int unsigned NHEX       = (WIDTH + 3) / 4;
   localparam int unsigned HEX_W      = 4 * NHEX;
   localparam int unsigned DEC_DIGITS = dec_digits(WIDTH);
   localparam int unsigned IDX_W      = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] BIN_TOP = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] HEX_TOP = IDX_W'(NHEX - 1);
   localparam logic [IDX_W-1:0] DEC_TOP = IDX_W'(DEC_DIGITS - 1);

   logic [1:0]       state;
   logic [1:0]       fmt_q;
   logic [WIDTH-1:0] data_q;
   logic [IDX_W-1:0] idx;
   logic             seen_nz;

   logic             accept;
   logic             in_dec;
   logic             in_neg;
   logic [WIDTH-1:0] in_mag;
   logic [IDX_W-1:0] lead_bin;
   logic [IDX_W-1:0] lead_hex;
   logic [IDX_W-1:0] first_idx;
   logic             skip;

   logic             dig_start;
   logic [WIDTH-1:0] dig_rem_in;
   logic [3:0]       dig_digit;
   logic [WIDTH-1:0] dig_rem;
   logic             dig_done;

   // ASCII character of bit/nibble i of v in binary or hex
   function automatic logic [7:0] radix_char(input logic [WIDTH-1:0] v,
                                             input logic [1:0]       f,
                                             input logic [IDX_W-1:0] i);
      logic [WIDTH-1:0] bsh;
      logic [HEX_W-1:0] hsh;
      logic [3:0]       nib;
      bsh = v >> i;
      hsh = HEX_W'(v) >> {i, 2'b00};
      nib = hsh[3:0];
      if (f == FMT_BIN)
         return bsh[0] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
      else if (nib < 4'd10)
         return ASCII_ZERO + {4'h0, nib};
      else
         return ASCII_A + {4'h0, nib} - 8'd10;
   endfunction

   assign in_ready = rst_n && (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign in_dec   = (in_fmt == FMT_UDEC) || (in_fmt == FMT_SDEC);
   assign in_neg   = (in_fmt == FMT_SDEC) && in_data[WIDTH-1];
   assign in_mag   = in_neg ? (~in_data + 1'b1) : in_data;
   assign skip     = ZERO_SUPPRESS && (dig_digit == 4'd0) && !seen_nz && (idx != '0);

   // Position of the most significant non-zero bit / nibble of the incoming value
   always_comb begin
      logic [HEX_W-1:0] sh;
      lead_bin = '0;
      lead_hex = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (in_data[i]) lead_bin = IDX_W'(i);
      end
      for (int unsigned i = 0; i < NHEX; i++) begin
         sh = HEX_W'(in_data) >> (4 * i);
         if (sh[3:0] != 4'h0) lead_hex = IDX_W'(i);
      end
      if (in_fmt == FMT_BIN)
         first_idx = ZERO_SUPPRESS ? lead_bin : BIN_TOP;
      else
         first_idx = ZERO_SUPPRESS ? lead_hex : HEX_TOP;
   end

   // Kick the digit extractor; the remainder chains from the previous digit
   always_comb begin
      dig_start  = 1'b0;
      dig_rem_in = dig_rem;
      case (state)
         S_IDLE: begin
            dig_start  = accept && in_dec && !in_neg;
            dig_rem_in = in_mag;
         end
         S_SIGN: begin
            dig_start  = out_ready;
            dig_rem_in = data_q;
         end
         S_CALC:  dig_start = dig_done && skip;
         S_EMIT:  dig_start = out_ready && !out_last && fmt_q[1];
         default: dig_start = 1'b0;
      endcase
   end

   num_fmt_dec_digit #(
      .WIDTH (WIDTH)
   ) u_dec_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (dig_start),
      .rem_in  (dig_rem_in),
      .pow     (pow10(32'(idx))),
      .digit   (dig_digit),
      .rem_out (dig_rem),
      .done    (dig_done)
   );

   // Main FSM and registered output character
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         fmt_q     <= '0;
         data_q    <= '0;
         idx       <= '0;
         seen_nz   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_char  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  fmt_q   <= in_fmt;
                  seen_nz <= 1'b0;
                  if (in_dec) begin
                     data_q <= in_mag;
                     idx    <= DEC_TOP;
                     if (in_neg) begin
                        out_char  <= ASCII_MINUS;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= S_SIGN;
                     end else begin
                        state <= S_CALC;
                     end
                  end else begin
                     data_q    <= in_data;
                     idx       <= first_idx;
                     out_char  <= radix_char(in_data, in_fmt, first_idx);
                     out_valid <= 1'b1;
                     out_last  <= (first_idx == '0);
                     state     <= S_EMIT;
                  end
               end
            end
            S_SIGN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_CALC;
               end
            end
            S_CALC: begin
               if (dig_done) begin
                  // A suppressed leading zero restarts the extractor on the next power
                  if (skip) begin
                     idx <= idx - 1'b1;
                  end else begin
                     out_char  <= ASCII_ZERO + {4'h0, dig_digit};
                     out_valid <= 1'b1;
                     out_last  <= (idx == '0);
                     seen_nz   <= 1'b1;
                     state     <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= S_IDLE;
                  end else if (fmt_q[1]) begin
                     idx       <= idx - 1'b1;
                     out_valid <= 1'b0;
                     state     <= S_CALC;
                  end else begin
                     idx      <= idx - 1'b1;
                     out_char <= radix_char(data_q, fmt_q, idx - 1'b1);
                     out_last <= (idx == IDX_W'(1));
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
